// File: rtl/cm0ik_ahb_pkg.sv
// Shared AHB-Lite constants, master state encoding and command legality check.
package cm0ik_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Non-cacheable, non-bufferable, privileged data access
    localparam logic [3:0] HPROT_VAL = 4'b0011;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StResp
    } state_e;

    // A command is legal when its size is byte/half/word and the address is naturally aligned
    function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        unique case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lo[0];
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cm0ik_ahb_master_if.sv
// Command/response stream plus AHB-Lite bus signals of the single-outstanding initiator.
interface cm0ik_ahb_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, rsp_ready,
        input  HREADY, HRESP, HRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, rsp_ready,
        output HREADY, HRESP, HRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

endinterface

// File: rtl/cm0ik_ahb_lanes.sv
// Byte-lane helper: replicates write data across HWDATA and extracts right-justified read data.
module cm0ik_ahb_lanes
    import cm0ik_ahb_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] hrdata,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    // Lane steering decoded from transfer size and low address bits
    always_comb begin
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;
        unique case (size)
            HSIZE_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'h0, hrdata[{addr_lo, 3'b000} +: 8]};
            end
            HSIZE_HALF: begin
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'h0, hrdata[{addr_lo[1], 4'b0000} +: 16]};
            end
            HSIZE_WORD: begin
                wdata_rep = wdata;
                rdata_ext = hrdata;
            end
            default: begin
                wdata_rep = 32'h0;
                rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/cm0ik_ahb_master.sv
// Single-outstanding AHB-Lite initiator: one command in, one NONSEQ transfer, one response out.
module cm0ik_ahb_master
    import cm0ik_ahb_pkg::*;
(
    input logic               HCLK,
    input logic               HRESETn,
    cm0ik_ahb_master_if.master bus
);

    state_e      state;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] wdata;
    logic [31:0] hwdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;

    cm0ik_ahb_lanes u_lanes (
        .size      (hsize),
        .addr_lo   (haddr[1:0]),
        .wdata     (wdata),
        .hrdata    (bus.HRDATA),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // Transfer sequencing; bus controls and response fields are all registered here
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state  <= StIdle;
            haddr  <= 32'h0;
            hwrite <= 1'b0;
            hsize  <= 3'b000;
            wdata  <= 32'h0;
            hwdata <= 32'h0;
            rdata  <= 32'h0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        if (cmd_legal(bus.cmd_size, bus.cmd_addr[1:0])) begin
                            haddr  <= bus.cmd_addr;
                            hwrite <= bus.cmd_write;
                            hsize  <= bus.cmd_size;
                            wdata  <= bus.cmd_wdata;
                            state  <= StAddr;
                        end else begin
                            // Rejected locally: the bus stays quiet and holds its last controls
                            rdata <= 32'h0;
                            err   <= 1'b1;
                            state <= StResp;
                        end
                    end
                end
                StAddr: begin
                    if (bus.HREADY) begin
                        hwdata <= wdata_rep;
                        state  <= StData;
                    end
                end
                StData: begin
                    // First ERROR cycle arrives with HREADY low and simply waits here
                    if (bus.HREADY) begin
                        err   <= bus.HRESP;
                        rdata <= (hwrite || bus.HRESP) ? 32'h0 : rdata_ext;
                        state <= StResp;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Handshake and HTRANS decoded from the state register only
    always_comb begin
        bus.cmd_ready = (state == StIdle);
        bus.rsp_valid = (state == StResp);
        bus.HTRANS    = (state == StAddr) ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
    assign bus.HADDR     = haddr;
    assign bus.HWRITE    = hwrite;
    assign bus.HSIZE     = hsize;
    assign bus.HWDATA    = hwdata;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_cm0ik_ahb_master.sv
// Bench for cm0ik_ahb_master: directed commands, a scripted slave, and a response scoreboard.
module tb_cm0ik_ahb_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic HCLK;
    logic HRESETn;
    int   checks;
    int   errors;
    int   nonseq_cnt;
    rsp_t exp_q[$];

    cm0ik_ahb_master_if bus ();

    cm0ik_ahb_master dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count address-phase NONSEQ cycles seen on the bus
    initial begin
        nonseq_cnt = 0;
        forever begin
            @(negedge HCLK);
            if (bus.HTRANS == 2'b10) nonseq_cnt++;
        end
    end

    // Scoreboard monitor: every response handshake is matched against the queue
    initial begin
        rsp_t e;
        forever begin
            @(negedge HCLK);
            if (HRESETn && bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
                end
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] wd, output bit ok);
        @(negedge HCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_write = wr;
        bus.cmd_size  = size;
        bus.cmd_wdata = wd;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge HCLK);
        end
        if (!ok) begin
            chk("cmd_accept_timeout", 32'd0, 32'd1);
            bus.cmd_valid = 1'b0;
        end else begin
            @(posedge HCLK);
            #1;
            bus.cmd_valid = 1'b0;
            bus.cmd_addr  = 32'hFFFF_FFFF;
            bus.cmd_wdata = 32'hFFFF_FFFF;
        end
    endtask

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wd, input logic legal, input int aw, input int dw,
                        input logic berr, input logic [31:0] hrdata, input logic [31:0] exp_hwdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        bit ok;
        int n0;
        n0 = nonseq_cnt;
        if (hold > 0) bus.rsp_ready = 1'b0;
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        issue(addr, wr, size, wd, ok);
        if (!ok) begin
            void'(exp_q.pop_back());
            bus.rsp_ready = 1'b1;
            return;
        end
        if (legal) begin
            for (int i = 0; i <= aw; i++) begin
                bus.HREADY = (i == aw);
                chk("htrans_nonseq", {30'h0, bus.HTRANS}, 32'd2);
                chk("haddr", bus.HADDR, addr);
                chk("hwrite", {31'h0, bus.HWRITE}, {31'h0, wr});
                chk("hsize", {29'h0, bus.HSIZE}, {29'h0, size});
                chk("cmd_ready_addr", {31'h0, bus.cmd_ready}, 32'd0);
                @(posedge HCLK);
                #1;
            end
            for (int i = 0; i <= dw; i++) begin
                bus.HREADY = (i == dw);
                bus.HRESP  = berr && (i >= dw - 1);
                bus.HRDATA = (i == dw) ? hrdata : ~hrdata;
                chk("htrans_data_idle", {30'h0, bus.HTRANS}, 32'd0);
                if (wr) chk("hwdata", bus.HWDATA, exp_hwdata);
                chk("cmd_ready_data", {31'h0, bus.cmd_ready}, 32'd0);
                @(posedge HCLK);
                #1;
            end
            bus.HREADY = 1'b1;
            bus.HRESP  = 1'b0;
            bus.HRDATA = 32'h0;
            chk("nonseq_cycles", nonseq_cnt - n0, aw + 1);
        end else begin
            chk("htrans_illegal", {30'h0, bus.HTRANS}, 32'd0);
        end
        chk("rsp_valid", {31'h0, bus.rsp_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_rsp_valid", {31'h0, bus.rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", bus.rsp_rdata, exp_rdata);
            chk("hold_rsp_err", {31'h0, bus.rsp_err}, {31'h0, exp_err});
            chk("hold_cmd_ready", {31'h0, bus.cmd_ready}, 32'd0);
            @(posedge HCLK);
            #1;
        end
        bus.rsp_ready = 1'b1;
        if (!legal) begin
            @(posedge HCLK);
            #1;
            chk("illegal_no_nonseq", nonseq_cnt - n0, 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, {31'h0, bus.cmd_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
        chk({tag, "_rsp_err"}, {31'h0, bus.rsp_err}, 32'd0);
        chk({tag, "_haddr"}, bus.HADDR, 32'h0);
        chk({tag, "_htrans"}, {30'h0, bus.HTRANS}, 32'd0);
        chk({tag, "_hwrite"}, {31'h0, bus.HWRITE}, 32'd0);
        chk({tag, "_hsize"}, {29'h0, bus.HSIZE}, 32'd0);
        chk({tag, "_hwdata"}, bus.HWDATA, 32'h0);
        chk({tag, "_hburst"}, {29'h0, bus.HBURST}, 32'd0);
        chk({tag, "_hprot"}, {28'h0, bus.HPROT}, 32'h3);
        chk({tag, "_hmastlock"}, {31'h0, bus.HMASTLOCK}, 32'd0);
    endtask

    initial begin
        bit ok;
        checks        = 0;
        errors        = 0;
        HRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_write = 1'b0;
        bus.cmd_size  = 3'd0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b1;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = 32'h0;
        #13;
        chk_reset_vals("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;

        //    addr        wr    size  wdata         legal aw dw err hrdata        hwdata        rdata         err  hold
        xfer(32'h400,   1'b1, 3'd2, 32'h0000FFFF, 1'b1, 0, 0, 1'b0, 32'h0,        32'h0000FFFF, 32'h0,        1'b0, 0);
        xfer(32'h003,   1'b0, 3'd0, 32'h0,        1'b1, 2, 2, 1'b0, 32'hA1B2C3D4, 32'h0,        32'h000000A1, 1'b0, 0);
        xfer(32'h102,   1'b1, 3'd1, 32'h1234BEEF, 1'b1, 1, 0, 1'b0, 32'h0,        32'hBEEFBEEF, 32'h0,        1'b0, 0);
        xfer(32'h102,   1'b0, 3'd1, 32'h0,        1'b1, 0, 1, 1'b0, 32'h12345678, 32'h0,        32'h00001234, 1'b0, 0);
        xfer(32'h006,   1'b0, 3'd2, 32'h0,        1'b0, 0, 0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 0);
        xfer(32'h000,   1'b0, 3'd3, 32'h0,        1'b0, 0, 0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 0);
        xfer(32'h001,   1'b0, 3'd1, 32'h0,        1'b0, 0, 0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 0);
        xfer(32'h200,   1'b0, 3'd2, 32'h0,        1'b1, 0, 1, 1'b1, 32'hDEADBEEF, 32'h0,        32'h0,        1'b1, 5);

        // Reset pulsed during a data-phase wait state; the in-flight response must vanish
        issue(32'h300, 1'b0, 3'd2, 32'h0, ok);
        if (ok) begin
            bus.HREADY = 1'b1;
            @(posedge HCLK);
            #1;
            bus.HREADY = 1'b0;
            @(posedge HCLK);
            #3;
            HRESETn = 1'b0;
            #1;
            chk_reset_vals("midreset");
            @(negedge HCLK);
            HRESETn    = 1'b1;
            bus.HREADY = 1'b1;
            repeat (3) @(posedge HCLK);
            #1;
            chk("post_reset_cmd_ready", {31'h0, bus.cmd_ready}, 32'd1);
            chk("post_reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        end

        xfer(32'h001,   1'b1, 3'd0, 32'hFFFFFF5A, 1'b1, 0, 0, 1'b0, 32'h0,        32'h5A5A5A5A, 32'h0,        1'b0, 0);
        xfer(32'h002,   1'b0, 3'd0, 32'h0,        1'b1, 0, 0, 1'b0, 32'h11223344, 32'h0,        32'h00000022, 1'b0, 0);
        xfer(32'h000,   1'b0, 3'd1, 32'h0,        1'b1, 1, 1, 1'b0, 32'h12345678, 32'h0,        32'h00005678, 1'b0, 0);
        xfer(32'h404,   1'b1, 3'd2, 32'hCAFEF00D, 1'b1, 1, 1, 1'b1, 32'hFFFFFFFF, 32'hCAFEF00D, 32'h0,        1'b1, 0);

        repeat (4) @(posedge HCLK);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
